multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath: one shared memory, IR/MDR/A/B/ALUOut holding registers.
//  Drives every datapath select/enable from a Moore FSM, one instruction per 3-5 cycles.
//  Supports add/sub/and/or/slt/sll/jr, beq, addi, ori, lw, sw, j, jal. Replaces the single-cycle control + AluCtl pairing.
//  Counts cycles/instructions and parks in HALTED when the program ends.
// PARAMETERS
//  CNT_W     32   width of cycle_count and instr_count
//  ALUOP_W   3    width of alu_op (encodings in package)
// PORTS
//  clk            in   1        rising-edge clock
//  rst            in   1        synchronous, active-high reset
//  opcode         in   6        IR[31:26], valid from DECODE onward
//  funct          in   6        IR[5:0]
//  zero           in   1        ALU zero flag, combinational, same cycle
//  halt_req       in   1        end-of-program request (sampled only in FETCH)
//  pc_write       out  1        unconditional PC load
//  pc_write_cond  out  1        PC load if zero (beq)
//  i_or_d         out  1        0 = memory address from PC, 1 = ALUOut
//  mem_read       out  1        memory read strobe
//  mem_write      out  1        memory write strobe
//  ir_write       out  1        IR load
//  reg_dst        out  2        0 = rt, 1 = rd, 2 = $31
//  mem_to_reg     out  2        0 = ALUOut, 1 = MDR, 2 = PC (link)
//  reg_write      out  1        register file write enable
//  alu_src_a      out  1        0 = PC, 1 = A
//  alu_src_b      out  2        0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
//  alu_op         out  ALUOP_W  to ALU control: ADD, SUB, RTYPE, OR
//  pc_source      out  2        0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = A (jr)
//  state          out  4        current state encoding (debug)
//  instr_done     out  1        1-cycle pulse in last state of each instruction
//  halted         out  1        high while in HALTED
//  cycle_count    out  CNT_W    cycles since reset, stops in HALTED
//  instr_count    out  CNT_W    retired instructions (counts instr_done)
// BEHAVIOUR
//  - Reset: state=FETCH, counters=0; all outputs 0 except those FETCH decodes (Moore, from state only, except pc_write_cond path).
//  - FETCH: mem_read, ir_write, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0, pc_write. halt_req=1 -> HALTED, no strobes asserted.
//  - DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALUOut). Next: lw/sw->MEMADR; R-type funct!=8->EXEC;
//    R-type funct==8->JR; beq->BRANCH; addi/ori->IEXEC; j/jal->JUMP; any other opcode->FETCH with instr_done=1 (NOP).
//  - MEMADR: src_a=1, src_b=2, ADD. lw->MEMRD, sw->MEMWR.  MEMRD: mem_read, i_or_d=1 -> MEMWB.
//  - MEMWB: reg_write, reg_dst=0, mem_to_reg=1, instr_done -> FETCH.  MEMWR: mem_write, i_or_d=1, instr_done -> FETCH.
//  - EXEC: src_a=1, src_b=0, RTYPE -> RWB.  RWB: reg_write, reg_dst=1, mem_to_reg=0, instr_done -> FETCH.
//  - IEXEC: src_a=1, src_b=2, alu_op=ADD (addi) / OR (ori) -> IWB.  IWB: reg_write, reg_dst=0, mem_to_reg=0, instr_done -> FETCH.
//  - BRANCH: src_a=1, src_b=0, SUB, pc_write_cond, pc_source=1, instr_done -> FETCH (PC loads only when zero=1).
//  - JUMP: pc_write, pc_source=2; jal also reg_write, reg_dst=2, mem_to_reg=2 (PC already +4). instr_done -> FETCH.
//  - JR: pc_write, pc_source=3, reg_write=0, instr_done -> FETCH.
//  - HALTED: absorbing; all strobes 0; only rst leaves it. cycle_count frozen.
//  - Latency: R/addi/ori 4 cycles, lw 5, sw 4, beq/j/jal/jr 3, unknown 2.
//  - mem_read and mem_write never high in same cycle; reg_write never high in FETCH/DECODE.
//  - Counters wrap modulo 2^CNT_W. instr_done and counter increment in same cycle.
//  - rst mid-instruction: next cycle is FETCH, no strobe asserted in the reset cycle except FETCH decode after release; counters 0.
//  - Illegal state encodings -> FETCH.
// STRUCTURE
//  - Package mips_pkg: opcode/funct localparams (OP_RTYPE, OP_BEQ, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_J, OP_JAL, FN_JR),
//    state encodings, ALU-op encodings (ADD=000, SUB=001, RTYPE=010, OR=100), mux select codes.
//  - One sub-module mc_next_state: combinational next-state from (state, opcode, funct, halt_req).
//  - Top: state register, output decode, counters.
// TESTING
//  - Reset for 2 cycles then release, halt_req=0 -> state=FETCH, pc_write=1, ir_write=1, mem_read=1, counts=0.
//  - opcode=100011 (lw) -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write only in cycle 5, mem_to_reg=1; instr_count=1.
//  - opcode=000100, zero=1 then zero=0 -> 3 cycles each, pc_write_cond=1 in BRANCH, pc_source=1 both times.
//  - opcode=000011 (jal) -> JUMP asserts pc_write, reg_write, reg_dst=2, mem_to_reg=2; opcode=0 funct=8 -> JR, pc_source=3, reg_write=0.
//  - opcode=111111 -> FETCH,DECODE,FETCH with instr_done in DECODE; no reg_write/mem_write ever.
//  - rst asserted in MEMRD -> FETCH next cycle, counters 0; halt_req=1 in FETCH -> halted=1, cycle_count stable 10 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control: opcodes, FSM states,
// ALU-op codes, mux selects and the bundled control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_RA  = 2'd2;
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MDR  = 2'd1;
  localparam logic [1:0] WB_PC   = 2'd2;
  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BOFF = 2'd3;
  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_REG    = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JR     = 4'd12,
    S_HALTED = 4'd13
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J)   || (op == OP_JAL) ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_ORI) ||
           (op == OP_LW)    || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_control_next_state.sv
// Combinational next-state logic for the multi-cycle control FSM.
import mips_pkg::*;

module mc_next_state (
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       halt_req_i,
  output state_e     next_o
);

  always_comb begin
    next_o = S_FETCH;
    case (state_i)
      S_FETCH:  next_o = halt_req_i ? S_HALTED : S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW:    next_o = S_MEMADR;
          OP_RTYPE:        next_o = (funct_i == FN_JR) ? S_JR : S_EXEC;
          OP_BEQ:          next_o = S_BRANCH;
          OP_ADDI, OP_ORI: next_o = S_IEXEC;
          OP_J, OP_JAL:    next_o = S_JUMP;
          default:         next_o = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode_i == OP_LW)      next_o = S_MEMRD;
        else if (opcode_i == OP_SW) next_o = S_MEMWR;
        else                        next_o = S_FETCH;
      end
      S_MEMRD:  next_o = S_MEMWB;
      S_EXEC:   next_o = S_RWB;
      S_IEXEC:  next_o = S_IWB;
      S_HALTED: next_o = S_HALTED;
      default:  next_o = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control: state register, per-state control decode and
// cycle/instruction counters.
import mips_pkg::*;

module multicycle_control #(
  parameter int CNT_W   = 32,
  parameter int ALUOP_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [5:0]         opcode_i,
  input  logic [5:0]         funct_i,
  input  logic               zero_i,
  input  logic               halt_req_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic               i_or_d_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic [1:0]         reg_dst_o,
  output logic [1:0]         mem_to_reg_o,
  output logic               reg_write_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic [1:0]         pc_source_o,
  output logic [3:0]         state_o,
  output logic               instr_done_o,
  output logic               halted_o,
  output logic [CNT_W-1:0]   cycle_count_o,
  output logic [CNT_W-1:0]   instr_count_o
);

  state_e           state_q, state_d;
  ctrl_t            ctl, ctl_gated;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  mc_next_state u_next (
    .state_i    (state_q),
    .opcode_i   (opcode_i),
    .funct_i    (funct_i),
    .halt_req_i (halt_req_i),
    .next_o     (state_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_FETCH;
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_source = PCS_ALU;
        // a pending halt abandons the fetch so PC and IR stay on the last instruction
        if (!halt_req_i) begin
          ctl.mem_read = 1'b1;
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        ctl.alu_src_b  = SRCB_BOFF;
        ctl.alu_op     = ALU_ADD;
        ctl.instr_done = !is_known_op(opcode_i);
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = DST_RT;
        ctl.mem_to_reg = WB_MDR;
        ctl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write  = 1'b1;
        ctl.i_or_d     = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_B;
        ctl.alu_op    = ALU_RTYPE;
      end
      S_RWB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = DST_RD;
        ctl.mem_to_reg = WB_ALU;
        ctl.instr_done = 1'b1;
      end
      S_IEXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = (opcode_i == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_IWB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = DST_RT;
        ctl.mem_to_reg = WB_ALU;
        ctl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_B;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCS_ALUOUT;
        ctl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = PCS_JUMP;
        ctl.instr_done = 1'b1;
        // PC already holds the return address from FETCH
        if (opcode_i == OP_JAL) begin
          ctl.reg_write  = 1'b1;
          ctl.reg_dst    = DST_RA;
          ctl.mem_to_reg = WB_PC;
        end
      end
      S_JR: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = PCS_REG;
        ctl.instr_done = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  // nothing strobes while reset is held, whatever state we were in
  assign ctl_gated = rst_i ? '0 : ctl;

  always_comb begin
    cycle_count_d = cycle_count_q;
    instr_count_d = instr_count_q;
    if (state_q != S_HALTED) cycle_count_d = cycle_count_q + 1'b1;
    if (ctl.instr_done)      instr_count_d = instr_count_q + 1'b1;
  end

  assign pc_write_o      = ctl_gated.pc_write;
  assign pc_write_cond_o = ctl_gated.pc_write_cond;
  assign i_or_d_o        = ctl_gated.i_or_d;
  assign mem_read_o      = ctl_gated.mem_read;
  assign mem_write_o     = ctl_gated.mem_write;
  assign ir_write_o      = ctl_gated.ir_write;
  assign reg_dst_o       = ctl_gated.reg_dst;
  assign mem_to_reg_o    = ctl_gated.mem_to_reg;
  assign reg_write_o     = ctl_gated.reg_write;
  assign alu_src_a_o     = ctl_gated.alu_src_a;
  assign alu_src_b_o     = ctl_gated.alu_src_b;
  assign alu_op_o        = ALUOP_W'(ctl_gated.alu_op);
  assign pc_source_o     = ctl_gated.pc_source;
  assign instr_done_o    = ctl_gated.instr_done;
  assign state_o         = state_q;
  assign halted_o        = (state_q == S_HALTED);
  assign cycle_count_o   = cycle_count_q;
  assign instr_count_o   = instr_count_q;

  // zero only gates the PC load in the datapath, not the sequencing
  logic unused_zero;
  assign unused_zero = zero_i;

endmodule
